// File: rtl/decrement_program_counter.sv
// decrement_program_counter: handshaked down-counting program counter that either
// wraps on borrow (one-cycle underflow pulse) or saturates to zero and halts.
module decrement_program_counter #(
    parameter int               WIDTH     = 4,
    parameter int               STEP      = 5,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             saturate,
    input  logic             pc_ready,
    output logic [WIDTH-1:0] pc_out,
    output logic             pc_valid,
    output logic             underflow
);
    typedef enum logic [1:0] {IDLE, ISSUE, HALT} state_t;
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
    state_t           state_q;
    logic [WIDTH-1:0] pc_q, diff;
    logic             valid_q, uf_q, borrow, accept;
    assign {borrow, diff} = {1'b0, pc_q} - {1'b0, STEP_W};
    assign accept = valid_q & pc_ready;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_VAL;
            valid_q <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    uf_q <= 1'b0;
                    if (load || en) begin
                        state_q <= ISSUE;
                        valid_q <= 1'b1;
                        if (load) pc_q <= load_val;
                    end
                end
                ISSUE: begin
                    uf_q <= 1'b0;
                    // load wins; a coincident accept just retires the old value
                    if (load) pc_q <= load_val;
                    else if (accept) begin
                        if (borrow && saturate) begin
                            pc_q    <= '0;
                            uf_q    <= 1'b1;
                            valid_q <= 1'b0;
                            state_q <= HALT;
                        end else begin
                            pc_q    <= diff;
                            uf_q    <= borrow;
                            valid_q <= en;
                            state_q <= en ? ISSUE : IDLE;
                        end
                    end
                end
                HALT: begin
                    if (load) begin
                        pc_q    <= load_val;
                        uf_q    <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end
    assign pc_out    = pc_q;
    assign pc_valid  = valid_q;
    assign underflow = uf_q;
endmodule

// File: tb/tb_decrement_program_counter.sv
// tb_decrement_program_counter: vector table plus hand sequences, checked through an expected-output queue.
module tb_decrement_program_counter;
    logic       clk = 1'b0;
    logic       reset = 1'b0, load = 1'b0, en = 1'b0, saturate = 1'b0, pc_ready = 1'b0;
    logic [3:0] load_val = '0;
    logic [3:0] pc_out;
    logic       pc_valid, underflow;
    int         total = 0, bad = 0, n_a = 0;

    typedef struct {
        logic rs, ld; logic [3:0] lv; logic en, sat, rdy;
        logic [3:0] pc; logic v, u;
    } vec_t;
    typedef struct { logic [3:0] pc; logic v, u; } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];

    decrement_program_counter #(.WIDTH(4), .STEP(5), .RESET_VAL(4'hF)) dut (
        .clk(clk), .reset(reset), .load(load), .load_val(load_val), .en(en),
        .saturate(saturate), .pc_ready(pc_ready), .pc_out(pc_out),
        .pc_valid(pc_valid), .underflow(underflow)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic rs, logic ld, logic [3:0] lv, logic e, logic sat,
                                logic rdy, logic [3:0] pc, logic v, logic u);
        vec_t r;
        r.rs = rs; r.ld = ld; r.lv = lv; r.en = e; r.sat = sat; r.rdy = rdy;
        r.pc = pc; r.v = v; r.u = u;
        return r;
    endfunction

    task automatic step(input vec_t t);
        exp_t e, got;
        reset = t.rs; load = t.ld; load_val = t.lv; en = t.en; saturate = t.sat; pc_ready = t.rdy;
        e.pc = t.pc; e.v = t.v; e.u = t.u;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        total++;
        if (pc_out !== got.pc || pc_valid !== got.v || underflow !== got.u) begin
            bad++;
            $display("FAIL step%0d pc/valid/uf got %0d/%0b/%0b want %0d/%0b/%0b",
                     total, pc_out, pc_valid, underflow, got.pc, got.v, got.u);
        end
    endtask

    initial begin
        // wrap run: 15,10,5,0,11 with one-cycle underflow on 11
        tbl.push_back(mk(1,0,0, 0,0,0, 15,0,0));
        tbl.push_back(mk(0,0,0, 1,0,1, 15,1,0));
        tbl.push_back(mk(0,0,0, 1,0,1, 10,1,0));
        tbl.push_back(mk(0,0,0, 1,0,1,  5,1,0));
        tbl.push_back(mk(0,0,0, 1,0,1,  0,1,0));
        tbl.push_back(mk(0,0,0, 1,0,1, 11,1,1));
        tbl.push_back(mk(0,0,0, 1,0,1,  6,1,0));
        tbl.push_back(mk(0,0,0, 0,0,1,  1,0,0));
        tbl.push_back(mk(0,0,0, 0,0,0,  1,0,0));
        // saturating run into HALT
        tbl.push_back(mk(1,0,0, 0,1,0, 15,0,0));
        tbl.push_back(mk(0,0,0, 1,1,1, 15,1,0));
        tbl.push_back(mk(0,0,0, 1,1,1, 10,1,0));
        tbl.push_back(mk(0,0,0, 1,1,1,  5,1,0));
        tbl.push_back(mk(0,0,0, 1,1,1,  0,1,0));
        tbl.push_back(mk(0,0,0, 1,1,1,  0,0,1));
        n_a = tbl.size();
        // leave HALT by load, then wrap, then saturate again
        tbl.push_back(mk(0,1,3, 0,0,0,  3,1,0));
        tbl.push_back(mk(0,0,0, 1,0,1, 14,1,1));
        tbl.push_back(mk(0,0,0, 1,0,1,  9,1,0));
        tbl.push_back(mk(0,0,0, 1,0,1,  4,1,0));
        tbl.push_back(mk(0,0,0, 1,1,1,  0,0,1));
        tbl.push_back(mk(0,1,10,1,0,0, 10,1,0));

        for (int i = 0; i < n_a; i++) step(tbl[i]);
        for (int i = 0; i < 12; i++) step(mk(0,0,0, 1,1,1, 0,0,1));
        for (int i = n_a; i < tbl.size(); i++) step(tbl[i]);

        // stall with en toggling, then accept
        step(mk(0,0,0, 0,0,0, 10,1,0));
        step(mk(0,0,0, 1,0,0, 10,1,0));
        step(mk(0,0,0, 0,0,0, 10,1,0));
        step(mk(0,0,0, 1,0,1,  5,1,0));
        // reset mid-ISSUE at pc=5 drops the offer
        step(mk(1,0,0, 1,0,1, 15,0,0));
        step(mk(0,0,0, 1,0,1, 15,1,0));
        step(mk(0,0,0, 1,0,1, 10,1,0));
        // load with coincident handshake, then continue
        step(mk(0,1,7, 1,0,1,  7,1,0));
        step(mk(0,0,0, 1,0,1,  2,1,0));
        step(mk(0,1,12,1,0,0, 12,1,0));
        // load from IDLE, accept with en low returns to IDLE
        step(mk(1,0,0, 0,0,0, 15,0,0));
        step(mk(0,1,9, 0,0,0,  9,1,0));
        step(mk(0,0,0, 0,0,1,  4,0,0));
        // reset while in HALT
        step(mk(0,0,0, 1,1,0,  4,1,0));
        step(mk(0,0,0, 1,1,1,  0,0,1));
        step(mk(1,0,0, 1,1,1, 15,0,0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/decrement_program_counter.md
DECREMENT_PROGRAM_COUNTER -- requirements
Module: decrement_program_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits.
REQ-002 SHALL have parameter STEP, default 5, decrement applied per accepted address.
REQ-003 SHALL have parameter RESET_VAL, default all ones (4'hF at WIDTH=4), counter value after reset.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous active-high reset.
REQ-007 SHALL have port load  input  1  parallel-load request.
REQ-008 SHALL have port load_val  input  WIDTH  value loaded when load=1.
REQ-009 SHALL have port en  input  1  run enable; starts issue from IDLE.
REQ-010 SHALL have port saturate  input  1  1 = stop at 0 on underflow, 0 = wrap modulo 2^WIDTH.
REQ-011 SHALL have port pc_ready  input  1  consumer (fetch unit) accepts pc_out.
REQ-012 SHALL have port pc_out  output  WIDTH  current program counter, registered.
REQ-013 SHALL have port pc_valid  output  1  pc_out offered to consumer, registered.
REQ-014 SHALL have port underflow  output  1  borrow indicator, registered.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, HALT; pc_valid=1 only in ISSUE.
REQ-016 IDLE: load=1 -> pc_out<=load_val, go ISSUE; else en=1 -> go ISSUE, pc_out unchanged; else stay.
REQ-017 ISSUE: handshake = pc_valid & pc_ready; without handshake and without load, pc_out and pc_valid SHALL hold (no retraction, no change when en drops).
REQ-018 ISSUE handshake, pc_out >= STEP: pc_out <= pc_out - STEP; stay ISSUE if en=1, else go IDLE.
REQ-019 ISSUE handshake, pc_out < STEP, saturate=0: pc_out <= (pc_out - STEP) mod 2^WIDTH, underflow=1 for exactly one cycle, next state per en as REQ-018.
REQ-020 ISSUE handshake, pc_out < STEP, saturate=1: pc_out <= 0, underflow<=1 sticky, go HALT.
REQ-021 pc_out = STEP exactly SHALL decrement to 0 with no underflow.
REQ-022 load in ISSUE SHALL take priority over decrement: pc_out <= load_val next cycle, stay ISSUE; a coincident handshake counts as acceptance of the old pc_out.
REQ-023 HALT: pc_valid=0, pc_out=0, underflow=1 held; only load (-> ISSUE, underflow<=0, pc_out<=load_val) or reset exits.
REQ-024 Latency: load or decrement visible on pc_out one cycle after the triggering edge; no combinational path input->output.
REQ-025 Subtraction SHALL be WIDTH-bit with borrow-out used as the underflow condition; STEP truncated to WIDTH bits.

Reset
REQ-026 reset=1 at a clock edge SHALL force state IDLE, pc_out=RESET_VAL, pc_valid=0, underflow=0, overriding load, en and handshake.
REQ-027 reset asserted mid-ISSUE or in HALT SHALL abandon any pending offer; no handshake is counted in that cycle.

Verification (WIDTH=4, STEP=5, RESET_VAL=15)
REQ-028 Reset, en=1, pc_ready=1, saturate=0 -> pc_out 15,10,5,0,11 on accepted cycles; underflow pulses 1 cycle with 11.
REQ-029 Same with saturate=1 -> 15,10,5,0 then HALT: pc_out=0, pc_valid=0, underflow=1 held for 10+ cycles.
REQ-030 pc_out=10 offered, pc_ready=0 for 3 cycles, en toggled -> pc_out=10, pc_valid=1 stable all 3 cycles; on ready=1, next pc_out=5.
REQ-031 pc_out=10, load=1 load_val=7 with handshake same cycle -> 10 counted accepted, next pc_out=7, pc_valid=1.
REQ-032 reset=1 while ISSUE with pc_out=5 -> next cycle pc_out=15, pc_valid=0, underflow=0, state IDLE.
REQ-033 In HALT, load=1 load_val=3 -> next cycle pc_out=3, pc_valid=1, underflow=0; handshake then wrap/saturate per saturate input.
